// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage MIPS pipeline: operand forwarding, load-use and
// branch stalls, a multi-cycle MUL/DIV busy countdown, a data-memory wait
// freeze, and a saturating count of fetch-stall cycles.
module hazard_unit_mc #(
  parameter int REG_AW = 5,
  parameter int MD_LAT = 4,
  parameter int MD_CW  = 8,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              BranchD,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic [REG_AW-1:0] RsE,
  input  logic [REG_AW-1:0] RtE,
  input  logic [REG_AW-1:0] WriteRegE,
  input  logic [REG_AW-1:0] WriteRegM,
  input  logic [REG_AW-1:0] WriteRegW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemToRegE,
  input  logic              MemToRegM,
  input  logic              MulDivStartE,
  input  logic              MulDivUseD,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushE,
  output logic              FlushW,
  output logic              ForwardAD,
  output logic              ForwardBD,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              MulDivBusy,
  output logic [PERF_W-1:0] StallCycles
);

  localparam logic [MD_CW-1:0]  MD_LOAD  = MD_CW'(MD_LAT);
  localparam logic [REG_AW-1:0] ZERO_REG = '0;

  logic [MD_CW-1:0] mdCnt;
  logic             lwStall;
  logic             branchStall;
  logic             mdStall;
  logic             memStall;
  logic             hazStall;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [PERF_W-1:0] satInc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction

  // A producer matches a consumer only when it writes a non-zero register.
  function automatic logic regHit(input logic [REG_AW-1:0] src,
                                  input logic [REG_AW-1:0] dst,
                                  input logic              we);
    return we && (src != ZERO_REG) && (src == dst);
  endfunction

  // M-stage result is newer than W-stage, so it wins when both match.
  function automatic logic [1:0] fwdSel(input logic [REG_AW-1:0] src);
    if (regHit(src, WriteRegM, RegWriteM)) return 2'b10;
    if (regHit(src, WriteRegW, RegWriteW)) return 2'b01;
    return 2'b00;
  endfunction

  assign memStall    = MemReqM && !MemReadyM;
  assign lwStall     = MemToRegE && (WriteRegE != ZERO_REG) &&
                       ((RsD == WriteRegE) || (RtD == WriteRegE));
  assign branchStall = BranchD &&
                       ((RegWriteE && (WriteRegE != ZERO_REG) &&
                         ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                        (MemToRegM && (WriteRegM != ZERO_REG) &&
                         ((WriteRegM == RsD) || (WriteRegM == RtD))));
  assign mdStall     = MulDivUseD && MulDivBusy;
  assign hazStall    = lwStall || branchStall || mdStall;
  assign MulDivBusy  = (mdCnt != '0);

  // Stall/flush/forward decode; a memory wait freezes F..M and outranks the rest.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (rst_n) begin
      ForwardAE = fwdSel(RsE);
      ForwardBE = fwdSel(RtE);
      ForwardAD = regHit(RsD, WriteRegM, RegWriteM);
      ForwardBD = regHit(RtD, WriteRegM, RegWriteM);
      if (memStall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (hazStall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  // MUL/DIV countdown; a start frozen in E by a memory wait is loaded once E moves.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mdCnt <= '0;
    end else if (MulDivStartE && !memStall) begin
      mdCnt <= MD_LOAD;
    end else if (mdCnt != '0) begin
      mdCnt <= mdCnt - MD_CW'(1);
    end
  end

  // Performance counter of cycles in which fetch was held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      StallCycles <= '0;
    end else if (StallF) begin
      StallCycles <= satInc(StallCycles);
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Self-checking bench for hazard_unit_mc: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_hazard_unit_mc;
  localparam int REG_AW  = 5;
  localparam int MD_LAT  = 4;
  localparam int MD_CW   = 8;
  localparam int PERF_W  = 4;
  localparam int CNT_MAX = (1 << PERF_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              BranchD;
  logic [REG_AW-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic              RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM;
  logic              MulDivStartE, MulDivUseD, MemReqM, MemReadyM;
  logic              StallF, StallD, StallE, StallM, FlushE, FlushW;
  logic              ForwardAD, ForwardBD, MulDivBusy;
  logic [1:0]        ForwardAE, ForwardBE;
  logic [PERF_W-1:0] StallCycles;

  int vectors = 0;
  int errors  = 0;
  int mdRem    = 0;
  int stallCnt = 0;
  logic [12:0] expVec;
  logic [12:0] actVec;

  hazard_unit_mc #(.REG_AW(REG_AW), .MD_LAT(MD_LAT), .MD_CW(MD_CW), .PERF_W(PERF_W)) dut (
    .clk(clk), .rst_n(rst_n), .BranchD(BranchD),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemToRegE(MemToRegE), .MemToRegM(MemToRegM),
    .MulDivStartE(MulDivStartE), .MulDivUseD(MulDivUseD),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MulDivBusy(MulDivBusy), .StallCycles(StallCycles)
  );

  always #5 clk = ~clk;

  assign actVec = {StallF, StallD, StallE, StallM, FlushE, FlushW,
                   ForwardAD, ForwardBD, ForwardAE, ForwardBE, MulDivBusy};

  // Which pipeline result should feed an E-stage operand.
  function automatic logic [1:0] fwdSrc(input logic [REG_AW-1:0] src);
    if (src == 0) return 2'd0;
    if (RegWriteM && WriteRegM == src) return 2'd2;
    if (RegWriteW && WriteRegW == src) return 2'd1;
    return 2'd0;
  endfunction

  // True when a D-stage source needs a value that producer p cannot yet supply.
  function automatic logic needsFrom(input logic [REG_AW-1:0] dst, input logic prod);
    return prod && (dst != 0) && (dst == RsD || dst == RtD);
  endfunction

  task automatic modelOutputs();
    logic [5:0] ctl;
    logic       memWait, hazard;
    memWait = MemReqM && !MemReadyM;
    hazard  = needsFrom(WriteRegE, MemToRegE) ||
              (BranchD && (needsFrom(WriteRegE, RegWriteE) || needsFrom(WriteRegM, MemToRegM))) ||
              (MulDivUseD && mdRem > 0);
    if (memWait)     ctl = 6'b111101;
    else if (hazard) ctl = 6'b110010;
    else             ctl = 6'b000000;
    if (!rst_n) expVec = {12'd0, mdRem > 0};
    else expVec = {ctl,
                   (RsD != 0 && RegWriteM && RsD == WriteRegM),
                   (RtD != 0 && RegWriteM && RtD == WriteRegM),
                   fwdSrc(RsE), fwdSrc(RtE), mdRem > 0};
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic sampleCheck();
    @(negedge clk);
    modelOutputs();
    vectors++;
    if (actVec !== expVec) begin
      errors++;
      $display("FAIL ctlVec: got %b, expected %b at %0t", actVec, expVec, $time);
    end
    chk("StallCycles", 32'(StallCycles), 32'(stallCnt));
  endtask

  task automatic advance();
    @(posedge clk);
    if (!rst_n) begin
      mdRem    = 0;
      stallCnt = 0;
    end else begin
      if (MulDivStartE && !(MemReqM && !MemReadyM)) mdRem = MD_LAT;
      else if (mdRem > 0) mdRem--;
      if (expVec[12] && stallCnt < CNT_MAX) stallCnt++;
    end
    #1;
  endtask

  task automatic idle();
    BranchD = 0; RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemToRegE = 0; MemToRegM = 0;
    MulDivStartE = 0; MulDivUseD = 0; MemReqM = 0; MemReadyM = 0;
  endtask

  initial begin
    idle();
    rst_n = 0;
    sampleCheck(); advance();
    sampleCheck(); chk("rstStallF", 32'(StallF), 0); chk("rstCnt", 32'(StallCycles), 0);
    advance();
    rst_n = 1;

    // Forwarding priority
    RsE = 3; WriteRegM = 3; RegWriteM = 1; WriteRegW = 3; RegWriteW = 1;
    sampleCheck(); chk("fwdPrioM", 32'(ForwardAE), 2); advance();
    RsE = 0;
    sampleCheck(); chk("fwdZeroReg", 32'(ForwardAE), 0); advance();
    RsE = 4; RegWriteM = 0; WriteRegW = 4;
    sampleCheck(); chk("fwdW", 32'(ForwardAE), 1); advance();
    idle();

    // Load-use
    MemToRegE = 1; WriteRegE = 5; RtD = 5;
    sampleCheck(); chk("lwStallF", 32'(StallF), 1); chk("lwFlushE", 32'(FlushE), 1); advance();
    idle();
    sampleCheck(); chk("lwClear", 32'(StallF), 0); chk("lwCnt", 32'(StallCycles), 1); advance();

    // Branch against E-stage ALU result, then M-stage load
    BranchD = 1; RegWriteE = 1; WriteRegE = 7; RsD = 7;
    sampleCheck(); chk("brE", 32'(StallD), 1); advance();
    RegWriteE = 0; WriteRegE = 0; MemToRegM = 1; WriteRegM = 7;
    sampleCheck(); chk("brM", 32'(StallD), 1); advance();
    idle();
    sampleCheck(); chk("brClear", 32'(StallD), 0); chk("brCnt", 32'(StallCycles), 3); advance();

    // MUL/DIV busy window
    MulDivStartE = 1; MulDivUseD = 1;
    sampleCheck(); chk("mdC0", 32'(StallD), 0); advance();
    MulDivStartE = 0;
    for (int i = 1; i <= 4; i++) begin
      sampleCheck(); chk("mdBusy", 32'(MulDivBusy), 1); chk("mdStall", 32'(StallD), 1); advance();
    end
    sampleCheck(); chk("mdRelease", 32'(StallD), 0); chk("mdCnt", 32'(StallCycles), 7); advance();
    idle();

    // Memory wait over a pending load-use
    MemToRegE = 1; WriteRegE = 5; RsD = 5; MemReqM = 1; MemReadyM = 0;
    for (int i = 0; i < 3; i++) begin
      sampleCheck(); chk("memStallM", 32'(StallM), 1); chk("memFlushW", 32'(FlushW), 1);
      chk("memFlushE", 32'(FlushE), 0); advance();
    end
    MemReadyM = 1;
    sampleCheck(); chk("memReadyStallM", 32'(StallM), 0); chk("memReadyFlushE", 32'(FlushE), 1); advance();
    idle();
    sampleCheck(); chk("memCnt", 32'(StallCycles), 11); advance();

    // Reset mid-operation
    MulDivStartE = 1;
    sampleCheck(); advance();
    MulDivStartE = 0;
    sampleCheck(); advance();
    rst_n = 0; MemToRegE = 1; WriteRegE = 5; RsD = 5; RsE = 2; WriteRegM = 2; RegWriteM = 1;
    sampleCheck(); chk("rstForceStall", 32'(StallF), 0); chk("rstForceFwd", 32'(ForwardAE), 0);
    chk("rstBusyPre", 32'(MulDivBusy), 1); advance();
    rst_n = 1; idle();
    sampleCheck(); chk("rstBusy", 32'(MulDivBusy), 0); chk("rstCntClr", 32'(StallCycles), 0); advance();

    // Counter saturation
    MemToRegE = 1; WriteRegE = 6; RtD = 6;
    for (int i = 0; i < 20; i++) begin sampleCheck(); advance(); end
    idle();
    sampleCheck(); chk("satCnt", 32'(StallCycles), CNT_MAX); advance();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      BranchD = $urandom_range(0, 1);
      RsD = $urandom_range(0, 3); RtD = $urandom_range(0, 3);
      RsE = $urandom_range(0, 3); RtE = $urandom_range(0, 3);
      WriteRegE = $urandom_range(0, 3); WriteRegM = $urandom_range(0, 3);
      WriteRegW = $urandom_range(0, 3);
      RegWriteE = $urandom_range(0, 1); RegWriteM = $urandom_range(0, 1);
      RegWriteW = $urandom_range(0, 1);
      MemToRegE = ($urandom_range(0, 3) == 0); MemToRegM = ($urandom_range(0, 3) == 0);
      MulDivStartE = ($urandom_range(0, 7) == 0); MulDivUseD = $urandom_range(0, 1);
      MemReqM = ($urandom_range(0, 2) == 0); MemReadyM = $urandom_range(0, 1);
      sampleCheck();
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
